// File: rtl/cpu_debug_controller_pkg.sv
// Shared definitions for the CPU debug controller: command opcodes, FSM
// states and the default core-stop settle time.
package cpu_debug_controller_pkg;

    localparam int STOP_SETTLE_DEFAULT = 2;

    typedef enum logic [2:0] {
        OP_HALT   = 3'b000,
        OP_RESUME = 3'b001,
        OP_READ   = 3'b010,
        OP_WRITE  = 3'b011,
        OP_DUMP   = 3'b100
    } dbg_op_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_READ   = 3'd2,
        ST_WRITE  = 3'd3,
        ST_DUMP   = 3'd4,
        ST_RESP   = 3'd5
    } dbg_state_e;

    // Register-file commands are only meaningful once the core is parked.
    function automatic logic op_needs_halt(input logic [2:0] op);
        return (op == OP_READ) || (op == OP_WRITE) || (op == OP_DUMP);
    endfunction

endpackage

// File: rtl/cpu_debug_controller_dbg_counter.sv
// Loadable up-counter with a terminal-count flag; it saturates at the
// terminal value so a sweep never wraps back to zero.
module dbg_counter
    import cpu_debug_controller_pkg::*;
#(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             inc,
    input  logic [WIDTH-1:0] terminal,
    output logic [WIDTH-1:0] count,
    output logic             tc
);

    assign tc = (count == terminal);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (inc && !tc) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/cpu_debug_controller.sv
// Debug controller: halts/resumes the core and gives register-file
// read, write and full-dump access through a command/response handshake.
module cpu_debug_controller
    import cpu_debug_controller_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int STOP_SETTLE    = STOP_SETTLE_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [2:0]                cmd_op,
    input  logic [REG_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0]     cmd_data,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_WIDTH-1:0]     rsp_data,
    output logic [REG_ADDR_WIDTH-1:0] rsp_addr,
    output logic                      rsp_last,
    output logic                      rsp_err,
    output logic                      halted,
    output logic                      cm_cpu_stop,
    output logic [REG_ADDR_WIDTH-1:0] cm_read_write_regfile_addr,
    output logic [DATA_WIDTH-1:0]     cm_write_regfile_dat,
    output logic                      cm_write_regfile_enb,
    input  logic [DATA_WIDTH-1:0]     cm_read_regfile_dat
);

    localparam int SETTLE_W = (STOP_SETTLE > 1) ? $clog2(STOP_SETTLE) : 1;
    localparam int CNT_W    = (SETTLE_W > REG_ADDR_WIDTH) ? SETTLE_W : REG_ADDR_WIDTH;
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(STOP_SETTLE - 1);
    localparam logic [CNT_W-1:0] DUMP_LAST   = CNT_W'((1 << REG_ADDR_WIDTH) - 1);

    dbg_state_e       state;
    logic [2:0]       op_q;
    logic [CNT_W-1:0] cnt;
    logic             cnt_tc;
    logic             cnt_load;
    logic             cnt_inc;
    logic [CNT_W-1:0] cnt_terminal;
    logic             dump_advance;

    // One counter serves both the settle wait and the dump sweep; the
    // latched op decides which terminal value applies.
    assign cnt_terminal = (op_q == OP_HALT) ? SETTLE_LAST : DUMP_LAST;
    assign cnt_load     = (state == ST_IDLE) && cmd_valid && cmd_ready;
    assign dump_advance = (state == ST_RESP) && rsp_ready && (op_q == OP_DUMP)
                          && !rsp_err && !rsp_last;
    assign cnt_inc      = (state == ST_SETTLE) || dump_advance;

    dbg_counter #(
        .WIDTH (CNT_W)
    ) u_counter (
        .clk        (clk),
        .rst        (rst),
        .load       (cnt_load),
        .load_value ('0),
        .inc        (cnt_inc),
        .terminal   (cnt_terminal),
        .count      (cnt),
        .tc         (cnt_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state                      <= ST_IDLE;
            op_q                       <= '0;
            cmd_ready                  <= 1'b1;
            rsp_valid                  <= 1'b0;
            rsp_data                   <= '0;
            rsp_addr                   <= '0;
            rsp_last                   <= 1'b0;
            rsp_err                    <= 1'b0;
            halted                     <= 1'b0;
            cm_cpu_stop                <= 1'b0;
            cm_read_write_regfile_addr <= '0;
            cm_write_regfile_dat       <= '0;
            cm_write_regfile_enb       <= 1'b0;
        end else begin
            cm_write_regfile_enb <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        op_q      <= cmd_op;
                        rsp_addr  <= cmd_addr;
                        rsp_data  <= '0;
                        rsp_last  <= 1'b1;
                        rsp_err   <= 1'b0;
                        if (op_needs_halt(cmd_op) && !halted) begin
                            rsp_err   <= 1'b1;
                            rsp_valid <= 1'b1;
                            state     <= ST_RESP;
                        end else begin
                            case (cmd_op)
                                OP_HALT: begin
                                    cm_cpu_stop <= 1'b1;
                                    if (halted || (STOP_SETTLE == 0)) begin
                                        halted    <= 1'b1;
                                        rsp_valid <= 1'b1;
                                        state     <= ST_RESP;
                                    end else begin
                                        state <= ST_SETTLE;
                                    end
                                end
                                OP_RESUME: begin
                                    cm_cpu_stop <= 1'b0;
                                    halted      <= 1'b0;
                                    rsp_valid   <= 1'b1;
                                    state       <= ST_RESP;
                                end
                                OP_READ: begin
                                    cm_read_write_regfile_addr <= cmd_addr;
                                    state                      <= ST_READ;
                                end
                                OP_WRITE: begin
                                    // Register 0 is hardwired: acknowledge without a strobe.
                                    cm_read_write_regfile_addr <= cmd_addr;
                                    cm_write_regfile_dat       <= cmd_data;
                                    cm_write_regfile_enb       <= (cmd_addr != '0);
                                    state                      <= ST_WRITE;
                                end
                                OP_DUMP: begin
                                    cm_read_write_regfile_addr <= '0;
                                    state                      <= ST_DUMP;
                                end
                                default: begin
                                    rsp_err   <= 1'b1;
                                    rsp_valid <= 1'b1;
                                    state     <= ST_RESP;
                                end
                            endcase
                        end
                    end
                end
                ST_SETTLE: begin
                    if (cnt_tc) begin
                        halted    <= 1'b1;
                        rsp_valid <= 1'b1;
                        state     <= ST_RESP;
                    end
                end
                ST_READ: begin
                    rsp_data  <= cm_read_regfile_dat;
                    rsp_valid <= 1'b1;
                    state     <= ST_RESP;
                end
                ST_WRITE: begin
                    rsp_valid <= 1'b1;
                    state     <= ST_RESP;
                end
                ST_DUMP: begin
                    rsp_data  <= cm_read_regfile_dat;
                    rsp_addr  <= cnt[REG_ADDR_WIDTH-1:0];
                    rsp_last  <= cnt_tc;
                    rsp_valid <= 1'b1;
                    state     <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        if (dump_advance) begin
                            cm_read_write_regfile_addr <= cnt[REG_ADDR_WIDTH-1:0] + 1'b1;
                            state                      <= ST_DUMP;
                        end else begin
                            cmd_ready <= 1'b1;
                            state     <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    cmd_ready <= 1'b1;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
